// File: rtl/ring_token_checker.sv
// Checks a one-hot ring counter token for validity and rotation order.
// Tracks lock state, counts completed revolutions and accumulates errors.
module ring_token_checker #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 2,
    parameter int REV_W    = 8,
    parameter int ERR_W    = 8,
    localparam int PW      = (N > 1) ? $clog2(N) : 1,
    localparam int GW      = $clog2(LOCK_CNT + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sample_en_i,
    input  logic [N-1:0]     ring_i,
    input  logic             clear_err_i,
    output logic [PW-1:0]    phase_o,
    output logic             phase_valid_o,
    output logic             locked_o,
    output logic             err_onehot_o,
    output logic             err_seq_o,
    output logic             rev_tick_o,
    output logic [REV_W-1:0] rev_count_o,
    output logic [ERR_W-1:0] err_count_o
);

    typedef enum logic [1:0] {ACQ, TRACK, LOCKED} state_t;

    state_t            state_q;
    logic [N-1:0]      ref_q;
    logic [GW-1:0]     good_q;
    logic [PW-1:0]     phase_q;
    logic              phase_valid_q;
    logic              locked_q;
    logic              err_onehot_q;
    logic              err_seq_q;
    logic              rev_tick_q;
    logic [REV_W-1:0]  rev_count_q;
    logic [ERR_W-1:0]  err_count_q;

    logic              is_onehot_d;
    logic [PW-1:0]     idx_d;
    logic [N-1:0]      expected_d;
    logic              in_seq_d;
    logic [GW-1:0]     good_inc_d;
    logic              err_event_d;

    always_comb begin
        is_onehot_d = (ring_i != '0) && ((ring_i & (ring_i - N'(1))) == '0);
        idx_d       = '0;
        for (int i = 0; i < N; i++) begin
            if (ring_i[i]) idx_d = i[PW-1:0];
        end
        // The token rotates toward bit 0, wrapping back into the MSB.
        expected_d  = {ref_q[0], ref_q[N-1:1]};
        in_seq_d    = (ring_i == expected_d);
        good_inc_d  = good_q + GW'(1);
        err_event_d = sample_en_i &&
                      (!is_onehot_d || (state_q != ACQ && !in_seq_d));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= ACQ;
            ref_q         <= '0;
            good_q        <= '0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            err_onehot_q  <= 1'b0;
            err_seq_q     <= 1'b0;
            rev_tick_q    <= 1'b0;
            rev_count_q   <= '0;
            err_count_q   <= '0;
        end else begin
            err_onehot_q <= 1'b0;
            err_seq_q    <= 1'b0;
            rev_tick_q   <= 1'b0;

            // Clear wins over a simultaneous error; otherwise saturate.
            if (clear_err_i) begin
                err_count_q <= '0;
            end else if (err_event_d && err_count_q != '1) begin
                err_count_q <= err_count_q + ERR_W'(1);
            end

            if (sample_en_i) begin
                if (!is_onehot_d) begin
                    state_q       <= ACQ;
                    good_q        <= '0;
                    err_onehot_q  <= 1'b1;
                    phase_valid_q <= 1'b0;
                    locked_q      <= 1'b0;
                end else begin
                    ref_q         <= ring_i;
                    phase_q       <= idx_d;
                    phase_valid_q <= 1'b1;
                    case (state_q)
                        ACQ: begin
                            good_q   <= '0;
                            state_q  <= TRACK;
                            locked_q <= 1'b0;
                        end
                        TRACK: begin
                            if (in_seq_d) begin
                                good_q <= good_inc_d;
                                if (good_inc_d == GW'(LOCK_CNT)) begin
                                    state_q  <= LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                err_seq_q <= 1'b1;
                                good_q    <= '0;
                            end
                        end
                        LOCKED: begin
                            if (in_seq_d) begin
                                if (ring_i == N'(1)) begin
                                    rev_tick_q  <= 1'b1;
                                    rev_count_q <= rev_count_q + REV_W'(1);
                                end
                            end else begin
                                err_seq_q <= 1'b1;
                                good_q    <= '0;
                                state_q   <= TRACK;
                                locked_q  <= 1'b0;
                            end
                        end
                        default: begin
                            state_q  <= ACQ;
                            good_q   <= '0;
                            locked_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign phase_o       = phase_q;
    assign phase_valid_o = phase_valid_q;
    assign locked_o      = locked_q;
    assign err_onehot_o  = err_onehot_q;
    assign err_seq_o     = err_seq_q;
    assign rev_tick_o    = rev_tick_q;
    assign rev_count_o   = rev_count_q;
    assign err_count_o   = err_count_q;

endmodule

// File: tb/tb_ring_token_checker.sv
// Directed scoreboard bench for ring_token_checker (N=4, LOCK_CNT=2, ERR_W=2).
// The driver queues hand-computed expectations; a monitor checks each cycle's outputs.
module tb_ring_token_checker;

    typedef struct packed {
        logic [1:0] ph;
        logic       pv;
        logic       lk;
        logic       eo;
        logic       es;
        logic       tk;
        logic [7:0] rev;
        logic [1:0] ec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sample_en = 1'b0;
    logic [3:0] ring = 4'b0000;
    logic       clear_err = 1'b0;
    logic [1:0] phase;
    logic       phase_valid;
    logic       locked;
    logic       err_onehot;
    logic       err_seq;
    logic       rev_tick;
    logic [7:0] rev_count;
    logic [1:0] err_count;

    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    exp_t exp_q[$];

    ring_token_checker #(.N(4), .LOCK_CNT(2), .REV_W(8), .ERR_W(2)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .sample_en_i  (sample_en),
        .ring_i       (ring),
        .clear_err_i  (clear_err),
        .phase_o      (phase),
        .phase_valid_o(phase_valid),
        .locked_o     (locked),
        .err_onehot_o (err_onehot),
        .err_seq_o    (err_seq),
        .rev_tick_o   (rev_tick),
        .rev_count_o  (rev_count),
        .err_count_o  (err_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] ph, input logic pv, input logic lk,
                                input logic eo, input logic es, input logic tk,
                                input logic [7:0] rev, input logic [1:0] ec);
        exp_t e;
        e.ph = ph; e.pv = pv; e.lk = lk; e.eo = eo; e.es = es; e.tk = tk;
        e.rev = rev; e.ec = ec;
        return e;
    endfunction

    // Apply one cycle of inputs and queue the response expected after the next edge.
    task automatic step(input logic rn, input logic en, input logic clr,
                        input logic [3:0] r, input exp_t e);
        @(negedge clk);
        rstn      = rn;
        sample_en = en;
        clear_err = clr;
        ring      = r;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        exp_t a;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {phase, phase_valid, locked, err_onehot, err_seq, rev_tick, rev_count, err_count};
            checks++;
            txn++;
            if (a !== e) begin
                errors++;
                $display("FAIL txn%0d outputs: got ph=%0d pv=%0b lk=%0b eo=%0b es=%0b tk=%0b rev=%0d ec=%0d, want ph=%0d pv=%0b lk=%0b eo=%0b es=%0b tk=%0b rev=%0d ec=%0d",
                         txn, a.ph, a.pv, a.lk, a.eo, a.es, a.tk, a.rev, a.ec,
                         e.ph, e.pv, e.lk, e.eo, e.es, e.tk, e.rev, e.ec);
            end else begin
                $display("txn%0d ok: ph=%0d pv=%0b lk=%0b eo=%0b es=%0b tk=%0b rev=%0d ec=%0d",
                         txn, a.ph, a.pv, a.lk, a.eo, a.es, a.tk, a.rev, a.ec);
            end
        end
    end

    initial begin
        logic [7:0] rev;
        int         waited;

        // Reset state
        step(1'b0, 1'b1, 1'b0, 4'b0001, mk(2'd0, 0, 0, 0, 0, 0, 8'd0, 2'd0));
        // Acquire, track, lock, first revolution
        step(1'b1, 1'b1, 1'b0, 4'b0001, mk(2'd0, 1, 0, 0, 0, 0, 8'd0, 2'd0));
        step(1'b1, 1'b1, 1'b0, 4'b1000, mk(2'd3, 1, 0, 0, 0, 0, 8'd0, 2'd0));
        step(1'b1, 1'b1, 1'b0, 4'b0100, mk(2'd2, 1, 1, 0, 0, 0, 8'd0, 2'd0));
        step(1'b1, 1'b1, 1'b0, 4'b0010, mk(2'd1, 1, 1, 0, 0, 0, 8'd0, 2'd0));
        step(1'b1, 1'b1, 1'b0, 4'b0001, mk(2'd0, 1, 1, 0, 0, 1, 8'd1, 2'd0));
        // Idle while locked with junk on the ring
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)), mk(2'd0, 1, 1, 0, 0, 0, 8'd1, 2'd0));
        end
        // Non-one-hot samples
        step(1'b1, 1'b1, 1'b0, 4'b0011, mk(2'd0, 0, 0, 1, 0, 0, 8'd1, 2'd1));
        step(1'b1, 1'b1, 1'b0, 4'b0000, mk(2'd0, 0, 0, 1, 0, 0, 8'd1, 2'd2));
        // Re-acquire and lock; a lock-entering 0001 does not tick
        step(1'b1, 1'b1, 1'b0, 4'b0100, mk(2'd2, 1, 0, 0, 0, 0, 8'd1, 2'd2));
        step(1'b1, 1'b1, 1'b0, 4'b0010, mk(2'd1, 1, 0, 0, 0, 0, 8'd1, 2'd2));
        step(1'b1, 1'b1, 1'b0, 4'b0001, mk(2'd0, 1, 1, 0, 0, 0, 8'd1, 2'd2));
        step(1'b1, 1'b1, 1'b0, 4'b1000, mk(2'd3, 1, 1, 0, 0, 0, 8'd1, 2'd2));
        step(1'b1, 1'b1, 1'b0, 4'b0100, mk(2'd2, 1, 1, 0, 0, 0, 8'd1, 2'd2));
        // Out-of-sequence sample while locked, then relock
        step(1'b1, 1'b1, 1'b0, 4'b0001, mk(2'd0, 1, 0, 0, 1, 0, 8'd1, 2'd3));
        step(1'b1, 1'b1, 1'b0, 4'b1000, mk(2'd3, 1, 0, 0, 0, 0, 8'd1, 2'd3));
        step(1'b1, 1'b1, 1'b0, 4'b0100, mk(2'd2, 1, 1, 0, 0, 0, 8'd1, 2'd3));
        // Saturation of the 2-bit error counter
        step(1'b1, 1'b1, 1'b0, 4'b0110, mk(2'd2, 0, 0, 1, 0, 0, 8'd1, 2'd3));
        step(1'b1, 1'b1, 1'b0, 4'b1111, mk(2'd2, 0, 0, 1, 0, 0, 8'd1, 2'd3));
        step(1'b1, 1'b1, 1'b0, 4'b0000, mk(2'd2, 0, 0, 1, 0, 0, 8'd1, 2'd3));
        // Clear beats a simultaneous error
        step(1'b1, 1'b1, 1'b1, 4'b0101, mk(2'd2, 0, 0, 1, 0, 0, 8'd1, 2'd0));
        step(1'b1, 1'b1, 1'b0, 4'b0000, mk(2'd2, 0, 0, 1, 0, 0, 8'd1, 2'd1));
        step(1'b1, 1'b0, 1'b1, 4'b1111, mk(2'd2, 0, 0, 0, 0, 0, 8'd1, 2'd0));
        // Lock again and run revolutions until rev_count reaches 5
        step(1'b1, 1'b1, 1'b0, 4'b0001, mk(2'd0, 1, 0, 0, 0, 0, 8'd1, 2'd0));
        step(1'b1, 1'b1, 1'b0, 4'b1000, mk(2'd3, 1, 0, 0, 0, 0, 8'd1, 2'd0));
        step(1'b1, 1'b1, 1'b0, 4'b0100, mk(2'd2, 1, 1, 0, 0, 0, 8'd1, 2'd0));
        step(1'b1, 1'b1, 1'b0, 4'b0010, mk(2'd1, 1, 1, 0, 0, 0, 8'd1, 2'd0));
        step(1'b1, 1'b1, 1'b0, 4'b0001, mk(2'd0, 1, 1, 0, 0, 1, 8'd2, 2'd0));
        rev = 8'd2;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'b1000, mk(2'd3, 1, 1, 0, 0, 0, rev, 2'd0));
            step(1'b1, 1'b1, 1'b0, 4'b0100, mk(2'd2, 1, 1, 0, 0, 0, rev, 2'd0));
            step(1'b1, 1'b1, 1'b0, 4'b0010, mk(2'd1, 1, 1, 0, 0, 0, rev, 2'd0));
            rev = rev + 8'd1;
            step(1'b1, 1'b1, 1'b0, 4'b0001, mk(2'd0, 1, 1, 0, 0, 1, rev, 2'd0));
        end
        // Reset mid-lock overrides sample_en and clear_err
        step(1'b0, 1'b1, 1'b1, 4'b1000, mk(2'd0, 0, 0, 0, 0, 0, 8'd0, 2'd0));
        step(1'b1, 1'b1, 1'b0, 4'b0010, mk(2'd1, 1, 0, 0, 0, 0, 8'd0, 2'd0));
        step(1'b1, 1'b0, 1'b0, 4'b0000, mk(2'd1, 1, 0, 0, 0, 0, 8'd0, 2'd0));

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_token_checker.md
RING_TOKEN_CHECKER -- requirements
Module: ring_token_checker

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the ring width in bits (N >= 2).
REQ-002 The block SHALL have parameter LOCK_CNT, default 2, giving the consecutive correct transitions needed to lock (>= 1).
REQ-003 The block SHALL have parameter REV_W, default 8, giving the revolution counter width.
REQ-004 The block SHALL have parameter ERR_W, default 8, giving the error counter width.
REQ-005 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 sample_en  input  1  high when ring holds a new value to check.
REQ-008 ring  input  N  one-hot token from the upstream ring counter.
REQ-009 clear_err  input  1  synchronous clear of err_count.
REQ-010 phase  output  clog2(N)  binary index of the set bit in the last accepted sample.
REQ-011 phase_valid  output  1  high when state is not ACQ.
REQ-012 locked  output  1  high in state LOCKED.
REQ-013 err_onehot  output  1  one-cycle pulse for a non-one-hot sample.
REQ-014 err_seq  output  1  one-cycle pulse for a one-hot sample that is out of sequence.
REQ-015 rev_tick  output  1  one-cycle pulse on each completed revolution while locked.
REQ-016 rev_count  output  REV_W  revolution counter.
REQ-017 err_count  output  ERR_W  error counter.

Function
REQ-018 The expected successor of reference sample r SHALL be {r[0], r[N-1:1]}, so the sequence is 0001 -> 1000 -> 0100 -> 0010 -> 0001 for N=4.
REQ-019 The FSM SHALL have states ACQ, TRACK and LOCKED, and SHALL store a reference sample ref and a good-transition counter good.
REQ-020 All outputs SHALL be registered, and every response to a sample SHALL appear one clock after the edge on which sample_en is high.
REQ-021 With sample_en low, state, ref, good, phase and both counters SHALL hold, and all pulse outputs SHALL be 0.
REQ-022 A sample with zero set bits or more than one set bit SHALL, in any state:
- pulse err_onehot
- move the FSM to ACQ
- clear good
- leave phase unchanged
REQ-023 In ACQ, a one-hot sample SHALL:
- load ref and phase from the sample
- clear good
- move the FSM to TRACK
REQ-024 In TRACK, a sample equal to the expected successor SHALL:
- load ref and phase from the sample
- increment good
- move the FSM to LOCKED when good reaches LOCK_CNT
REQ-025 In TRACK or LOCKED, a one-hot sample that differs from the expected successor SHALL:
- pulse err_seq
- resynchronise ref and phase to the sample
- clear good
- move the FSM to TRACK
REQ-026 In LOCKED, a correct sample SHALL keep the FSM in LOCKED and update ref and phase.
REQ-027 In LOCKED, a correct sample equal to 1 (bit 0 set) SHALL pulse rev_tick and increment rev_count modulo 2^REV_W.
REQ-028 err_count SHALL increment on each err_onehot or err_seq pulse, and SHALL saturate at 2^ERR_W-1.
REQ-029 When clear_err is high on the same edge as an error, clear_err SHALL take priority and err_count SHALL become 0.
REQ-030 rev_count SHALL NOT be cleared by clear_err.

Reset
REQ-031 With rstn low at a rising edge, the block SHALL set:
- state to ACQ
- ref, good, phase, rev_count and err_count to 0
- phase_valid, locked and all pulses to 0
REQ-032 Reset SHALL override sample_en and clear_err, and SHALL take effect from any state, including mid-lock.

Verification
REQ-033 With N=4 and LOCK_CNT=2, consecutive samples 0001, 1000, 0100, 0010, 0001 -> TRACK after the 1st sample, locked=1 after the 3rd, phase=2, 1, 0 in order, a rev_tick after the 5th, rev_count=1, no error pulses.
REQ-034 While locked, sample 0011 -> err_onehot pulse, locked=0, phase_valid=0, err_count=1; a following sample of 0000 -> a second err_onehot and err_count=2.
REQ-035 Locked with ref=0100, sample 0001 -> err_seq pulse, locked=0, phase=0; then samples 1000 and 0100 -> locked=1 again.
REQ-036 Locked, sample_en low for 10 cycles with random ring values -> outputs unchanged and no pulses.
REQ-037 With ERR_W=2, five error samples -> err_count stays at 3; an error with clear_err high on the same edge -> err_count=0.
REQ-038 rstn low for one edge while LOCKED with rev_count=5 -> all outputs 0 on the next cycle; the next one-hot sample -> TRACK.
